// File: rtl/beta_wb_stage_if.sv
// Execute/decode-facing bus of the write-back stage: retire request,
// next PC, destination register, and the two bypassed register read ports.
interface beta_wb_stage_if #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic [DataWidth-1:0]    wb_result_i;
    logic [4:0]              wb_rd_addr_i;
    logic                    wb_reg_wr_en_i;
    logic [AddressWidth-1:0] wb_next_pc_i;
    logic                    wb_op_end_i;
    logic                    wb_exe_busy_i;
    logic [4:0]              wb_rs1_addr_i;
    logic [4:0]              wb_rs2_addr_i;
    logic [DataWidth-1:0]    wb_rs1_data_o;
    logic [DataWidth-1:0]    wb_rs2_data_o;
    logic [AddressWidth-1:0] wb_pc_o;
    logic                    wb_retire_o;
    logic [63:0]             wb_instret_o;

    // Execute and decode side: drives requests, observes architectural state.
    modport master (
        output wb_result_i, wb_rd_addr_i, wb_reg_wr_en_i, wb_next_pc_i,
               wb_op_end_i, wb_exe_busy_i, wb_rs1_addr_i, wb_rs2_addr_i,
        input  wb_rs1_data_o, wb_rs2_data_o, wb_pc_o, wb_retire_o, wb_instret_o
    );

    // Write-back stage side.
    modport slave (
        input  wb_result_i, wb_rd_addr_i, wb_reg_wr_en_i, wb_next_pc_i,
               wb_op_end_i, wb_exe_busy_i, wb_rs1_addr_i, wb_rs2_addr_i,
        output wb_rs1_data_o, wb_rs2_data_o, wb_pc_o, wb_retire_o, wb_instret_o
    );
endinterface

// File: rtl/beta_wb_stage.sv
// Write-back stage: captures retiring execute results, commits them to the
// integer register file one cycle later, and serves two bypassed read ports.
module beta_wb_stage #(
    parameter int                    DataWidth    = 32,
    parameter int                    AddressWidth = 32,
    parameter int                    RegNum       = 32,
    parameter logic [AddressWidth-1:0] BootAddress = '0
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    beta_wb_stage_if.slave  wb
);

    logic                    ret;
    logic [DataWidth-1:0]    result_q;
    logic [4:0]              rd_q;
    logic                    we_q;
    logic [AddressWidth-1:0] pc_q;
    logic [63:0]             instret_q;
    logic                    retire_q;
    logic [DataWidth-1:0]    rf [RegNum];

    assign ret = wb.wb_op_end_i & ~wb.wb_exe_busy_i;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            result_q  <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            pc_q      <= BootAddress;
            instret_q <= '0;
            retire_q  <= 1'b0;
        end else if (ret) begin
            result_q  <= wb.wb_result_i;
            rd_q      <= wb.wb_rd_addr_i;
            we_q      <= wb.wb_reg_wr_en_i & (wb.wb_rd_addr_i != 5'd0);
            pc_q      <= wb.wb_next_pc_i;
            instret_q <= instret_q + 64'd1;
            retire_q  <= 1'b1;
        end else begin
            we_q      <= 1'b0;
            retire_q  <= 1'b0;
        end
    end

    // NOTE: the register file must read zero after reset, so it is built from
    // resettable flops rather than a RAM macro; x0 is never written (we_q
    // excludes rd 0), so entry 0 stays zero.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < RegNum; i++) begin
                rf[i] <= '0;
            end
        end else if (we_q) begin
            rf[rd_q] <= result_q;
        end
    end

    // A pending commit is forwarded so a retire is visible one edge early.
    function automatic logic [DataWidth-1:0] read_port(input logic [4:0] idx);
        logic [DataWidth-1:0] data;
        if (idx == 5'd0) begin
            data = '0;
        end else if (we_q && (rd_q == idx)) begin
            data = result_q;
        end else begin
            data = rf[idx];
        end
        return data;
    endfunction

    // NOTE: each combinational output is given a default first so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        wb.wb_rs1_data_o = '0;
        wb.wb_rs2_data_o = '0;
        wb.wb_rs1_data_o = read_port(wb.wb_rs1_addr_i);
        wb.wb_rs2_data_o = read_port(wb.wb_rs2_addr_i);
    end

    assign wb.wb_pc_o      = pc_q;
    assign wb.wb_retire_o  = retire_q;
    assign wb.wb_instret_o = instret_q;

endmodule

// File: tb/tb_beta_wb_stage.sv
// Bench for beta_wb_stage: a hand-derived vector table, reset-with-pending-write
// sequences, and random traffic against an architectural-state model.
module tb_beta_wb_stage;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    beta_wb_stage_if #(.DataWidth(32), .AddressWidth(32)) bus ();

    beta_wb_stage #(
        .DataWidth(32), .AddressWidth(32), .RegNum(32), .BootAddress(32'h0000_0000)
    ) dut (
        .clk_i (clk),
        .rstn_i(rstn),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: a retire updates the visible state immediately.
    logic [31:0] m_rf [32];
    logic [31:0] m_pc;
    logic [63:0] m_instret;
    logic        m_retire;

    typedef struct {
        logic        op_end;
        logic        busy;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] npc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic [31:0] e_pc;
        logic        e_ret;
        logic [63:0] e_inst;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic op_end, input logic busy, input logic we,
                         input logic [4:0] rd, input logic [31:0] res, input logic [31:0] npc);
        bus.wb_op_end_i    = op_end;
        bus.wb_exe_busy_i  = busy;
        bus.wb_reg_wr_en_i = we;
        bus.wb_rd_addr_i   = rd;
        bus.wb_result_i    = res;
        bus.wb_next_pc_i   = npc;
    endtask

    // Advance one edge, then present read addresses and let them settle.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2);
        @(posedge clk);
        #1;
        bus.wb_rs1_addr_i = rs1;
        bus.wb_rs2_addr_i = rs2;
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_pc      = 32'h0;
        m_instret = '0;
        m_retire  = 1'b0;
    endtask

    task automatic model_edge();
        m_retire = bus.wb_op_end_i & ~bus.wb_exe_busy_i;
        if (m_retire) begin
            if (bus.wb_reg_wr_en_i && bus.wb_rd_addr_i != 5'd0)
                m_rf[bus.wb_rd_addr_i] = bus.wb_result_i;
            m_pc      = bus.wb_next_pc_i;
            m_instret = m_instret + 64'd1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".rs1"}, 64'(bus.wb_rs1_data_o), 64'(m_rf[bus.wb_rs1_addr_i]));
        check({tag, ".rs2"}, 64'(bus.wb_rs2_data_o), 64'(m_rf[bus.wb_rs2_addr_i]));
        check({tag, ".pc"}, 64'(bus.wb_pc_o), 64'(m_pc));
        check({tag, ".retire"}, 64'(bus.wb_retire_o), 64'(m_retire));
        check({tag, ".instret"}, bus.wb_instret_o, m_instret);
    endtask

    function automatic vec_t mk(input logic op_end, input logic busy, input logic we,
                                input logic [4:0] rd, input logic [31:0] res, input logic [31:0] npc,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] e_rs1, input logic [31:0] e_rs2,
                                input logic [31:0] e_pc, input logic e_ret, input logic [63:0] e_inst);
        vec_t v;
        v.op_end = op_end; v.busy = busy; v.we = we; v.rd = rd; v.res = res; v.npc = npc;
        v.rs1 = rs1; v.rs2 = rs2; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
        v.e_pc = e_pc; v.e_ret = e_ret; v.e_inst = e_inst;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        // Expected values after each edge, derived by hand from the retire rules.
        vecs[0]  = mk(1, 0, 1, 5'd3, 32'hDEADBEEF, 32'h104, 5'd3, 5'd0, 32'hDEADBEEF, 32'h0, 32'h104, 1, 64'd1);
        vecs[1]  = mk(0, 0, 0, 5'd0, 32'h0,        32'h0,   5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h104, 0, 64'd1);
        vecs[2]  = mk(1, 1, 1, 5'd5, 32'h55,       32'h200, 5'd5, 5'd3, 32'h0, 32'hDEADBEEF, 32'h104, 0, 64'd1);
        vecs[3]  = mk(1, 1, 1, 5'd5, 32'h55,       32'h200, 5'd5, 5'd3, 32'h0, 32'hDEADBEEF, 32'h104, 0, 64'd1);
        vecs[4]  = mk(1, 1, 1, 5'd5, 32'h55,       32'h200, 5'd5, 5'd3, 32'h0, 32'hDEADBEEF, 32'h104, 0, 64'd1);
        vecs[5]  = mk(1, 0, 1, 5'd5, 32'h55,       32'h200, 5'd5, 5'd3, 32'h55, 32'hDEADBEEF, 32'h200, 1, 64'd2);
        vecs[6]  = mk(0, 0, 0, 5'd0, 32'h0,        32'h0,   5'd5, 5'd5, 32'h55, 32'h55, 32'h200, 0, 64'd2);
        vecs[7]  = mk(1, 0, 1, 5'd7, 32'h11,       32'h204, 5'd7, 5'd5, 32'h11, 32'h55, 32'h204, 1, 64'd3);
        vecs[8]  = mk(1, 0, 1, 5'd7, 32'h22,       32'h208, 5'd7, 5'd7, 32'h22, 32'h22, 32'h208, 1, 64'd4);
        vecs[9]  = mk(0, 0, 0, 5'd0, 32'h0,        32'h0,   5'd7, 5'd0, 32'h22, 32'h0, 32'h208, 0, 64'd4);
        vecs[10] = mk(1, 0, 1, 5'd0, 32'hFFFFFFFF, 32'h20C, 5'd0, 5'd0, 32'h0, 32'h0, 32'h20C, 1, 64'd5);
        vecs[11] = mk(0, 0, 0, 5'd0, 32'h0,        32'h0,   5'd0, 5'd7, 32'h0, 32'h22, 32'h20C, 0, 64'd5);
        vecs[12] = mk(1, 0, 0, 5'd3, 32'h99,       32'h210, 5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h210, 1, 64'd6);
        vecs[13] = mk(0, 0, 1, 5'd3, 32'h77,       32'h0,   5'd3, 5'd7, 32'hDEADBEEF, 32'h22, 32'h210, 0, 64'd6);

        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        bus.wb_rs1_addr_i = 5'd5;
        bus.wb_rs2_addr_i = 5'd0;
        rstn = 1'b0;
        #12;
        check("reset.rs1", 64'(bus.wb_rs1_data_o), 64'h0);
        check("reset.rs2", 64'(bus.wb_rs2_data_o), 64'h0);
        check("reset.pc", 64'(bus.wb_pc_o), 64'h0);
        check("reset.retire", 64'(bus.wb_retire_o), 64'h0);
        check("reset.instret", bus.wb_instret_o, 64'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op_end, vecs[i].busy, vecs[i].we, vecs[i].rd, vecs[i].res, vecs[i].npc);
            step(vecs[i].rs1, vecs[i].rs2);
            check($sformatf("vec%0d.rs1", i), 64'(bus.wb_rs1_data_o), 64'(vecs[i].e_rs1));
            check($sformatf("vec%0d.rs2", i), 64'(bus.wb_rs2_data_o), 64'(vecs[i].e_rs2));
            check($sformatf("vec%0d.pc", i), 64'(bus.wb_pc_o), 64'(vecs[i].e_pc));
            check($sformatf("vec%0d.retire", i), 64'(bus.wb_retire_o), 64'(vecs[i].e_ret));
            check($sformatf("vec%0d.instret", i), bus.wb_instret_o, vecs[i].e_inst);
        end

        // Reset arrives while the retire to x9 is still waiting to commit.
        drive(1, 0, 1, 5'd9, 32'h9999_0009, 32'h300);
        step(5'd9, 5'd9);
        check("rst_pend.bypass", 64'(bus.wb_rs1_data_o), 64'h9999_0009);
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        rstn = 1'b0;
        #1;
        check("rst_pend.rs1_in_reset", 64'(bus.wb_rs1_data_o), 64'h0);
        check("rst_pend.pc_in_reset", 64'(bus.wb_pc_o), 64'h0);
        check("rst_pend.retire_in_reset", 64'(bus.wb_retire_o), 64'h0);
        step(5'd9, 5'd7);
        rstn = 1'b1;
        step(5'd9, 5'd7);
        check("rst_pend.rf9", 64'(bus.wb_rs1_data_o), 64'h0);
        check("rst_pend.rf7", 64'(bus.wb_rs2_data_o), 64'h0);
        check("rst_pend.pc", 64'(bus.wb_pc_o), 64'h0);
        check("rst_pend.instret", bus.wb_instret_o, 64'h0);

        // Random traffic; small register range forces bypass collisions.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
                rstn = 1'b0;
                #1;
                model_reset();
                step(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
                rstn = 1'b1;
                check_model($sformatf("rand_rst%0d", c));
            end else begin
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 4) != 0), 5'($urandom_range(0, 7)),
                      $urandom, $urandom);
                model_edge();
                if ($urandom_range(0, 3) == 0)
                    step(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
                else
                    step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                check_model($sformatf("rand%0d", c));
            end
        end

        // Let any pending commit land, then sweep the whole file.
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        model_edge();
        step(5'd0, 5'd0);
        for (int r = 0; r < 32; r++) begin
            bus.wb_rs1_addr_i = 5'(r);
            bus.wb_rs2_addr_i = 5'(31 - r);
            #1;
            check($sformatf("sweep%0d.rs1", r), 64'(bus.wb_rs1_data_o), 64'(m_rf[r]));
            check($sformatf("sweep%0d.rs2", r), 64'(bus.wb_rs2_data_o), 64'(m_rf[31 - r]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
